sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
Serial stimulus source for the 01[0*]1 detector. It emits a programmable number of frames of the form 0,1,0^k,1 on a single-bit line, one bit per enabled clock, and its output drives the detector's sig_to_test input. It keeps a two-digit BCD count of frames sent and shows it on two 7-segment displays, so its count can be checked against the detector's own display.

Parameters:
MAX_ZEROS, 15, largest legal k. zeros_len width is clog2(MAX_ZEROS+1).
FRAME_W, 8, width of num_frames.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low; sampled on rising clk only
ena  in  1  advance enable; low stalls every register
start  in  1  request a burst; sampled only in IDLE with ena=1
zeros_len  in  clog2(MAX_ZEROS+1)  k, the number of zeros between the 1s; latched on accepted start
num_frames  in  FRAME_W  frames in the burst; latched on accepted start
sig_out  out  1  serial bit to the detector
sig_valid  out  1  sig_out carries a frame bit this cycle
busy  out  1  high from the accepted start until the burst ends
done  out  1  one-cycle pulse at burst end
frame_tick  out  1  high with the final 1 of each frame
count_bcd  out  8  frames sent, {tens, ones} in BCD, 00-99
disp0  out  8  ones digit in 7-seg code
disp1  out  8  tens digit in 7-seg code

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; sig_out=0, sig_valid=0, busy=0, done=0, frame_tick=0, count_bcd=8'h00, disp0=disp1=8'hC0.
- All outputs are registered. ena=0 freezes the state, the counters and every output. A done pulse in flight also holds, so it stays high until the next enabled edge.
- States: IDLE, LEAD0, LEAD1, GAP, END1.
- IDLE: the edge with start=1 and ena=1 latches zeros_len and num_frames, sets busy=1, and goes to LEAD0. The first bit appears on the following cycle.
- IDLE with num_frames=0 latched: stay in IDLE, busy stays 0, done pulses for 1 cycle, no bits are emitted.
- LEAD0: sig_out=0, sig_valid=1. Next state is LEAD1.
- LEAD1: sig_out=1. Next state is GAP if k>0, otherwise END1.
- GAP: sig_out=0 for exactly k cycles, tracked by an internal down-counter. Then END1.
- END1: sig_out=1 and frame_tick=1.
  - count_bcd increments on the edge leaving END1. Ones wrap 9->0 with a carry into tens. 99 wraps to 00.
  - If frames remain: go to LEAD0. Frames are back-to-back with no idle bit.
  - If no frames remain: go to IDLE with sig_valid=0, sig_out=0, busy=0, and done=1 for one cycle.
- Frame length is k+3 cycles. A burst of N frames occupies N*(k+3) enabled cycles from the first bit to the last.
- start while busy is ignored. start held high at burst end begins a new burst on the edge after the done cycle; IDLE lasts at least one cycle.
- count_bcd is cleared only by reset and accumulates across bursts.
- zeros_len > MAX_ZEROS at start is clamped to MAX_ZEROS.
- rst=0 mid-frame: abort on that edge, go to the reset values. No done pulse, and the partial frame is not counted.
- 7-seg code is {dp,g,f,e,d,c,b,a}, active-low, dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
- disp0 and disp1 update on the same edge as count_bcd.

Optional Feature:
Macro SEQGEN_IDLE_GAP_EN.
- Defined: after END1, when more frames remain, the block inserts one idle cycle (sig_valid=0, sig_out=0) before the next LEAD0. Frame spacing becomes k+4 cycles, and the burst length becomes N*(k+4)-1 cycles.
- Undefined: frames are back-to-back as described in Behaviour.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release, ena=1, start=0 for 10 cycles -> sig_valid=0, busy=0, count_bcd=00, disp0=disp1=C0 throughout.
- Single frame with k=2, N=1: sig_out must read 0,1,0,0,1 on 5 consecutive cycles with sig_valid=1; frame_tick only on the 5th cycle; then done pulses once; count_bcd=01, disp0=F9.
- k=0, N=3: the stream is 011 repeated 3 times (9 bits) -> frame_tick fires 3 times, count_bcd=03, disp0=B0, busy high for 9 cycles.
- ena gating: k=1, N=1, drop ena for 3 cycles after the second bit -> sig_out holds at 1 during the stall; the full stream is still 0,1,0,1.
- Wrap: run bursts totalling 100 frames -> count_bcd goes 99 to 00, disp1 goes 90 to C0, and no other side effects.
- Abort and edge cases:
  - N=5, k=3, assert rst=0 during the second frame's GAP -> outputs return to reset values immediately, count_bcd=00, no done pulse.
  - A new start with N=0 -> done pulses once and no bits are emitted.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial 0,1,0^k,1 frame source with a BCD frame counter and 7-seg display.
// Define SEQGEN_IDLE_GAP_EN to insert one idle bit between frames of a burst.
module sequence_generator #(
  parameter  int MAX_ZEROS = 15,
  parameter  int FRAME_W   = 8,
  localparam int ZW        = $clog2(MAX_ZEROS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic [ZW-1:0]      zeros_len,
  input  logic [FRAME_W-1:0] num_frames,
  output logic               sig_out,
  output logic               sig_valid,
  output logic               busy,
  output logic               done,
  output logic               frame_tick,
  output logic [7:0]         count_bcd,
  output logic [7:0]         disp0,
  output logic [7:0]         disp1
);

  typedef enum logic [2:0] {
    IDLE, LEAD0, LEAD1, GAP, END1, SPACE
  } state_t;

  state_t             state, state_d;
  logic [ZW-1:0]      k_q, k_d, gap_q, gap_d, k_in;
  logic [FRAME_W-1:0] rem_q, rem_d;
  logic [7:0]         bcd_d, disp0_d, disp1_d;
  logic               so_d, sv_d, busy_d, done_d, tick_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    logic [3:0] o, t;
    o = b[3:0];
    t = b[7:4];
    if (o == 4'd9) begin
      o = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // widen before comparing so the clamp stays meaningful for any MAX_ZEROS
  always_comb begin
    k_in = zeros_len;
    if ({1'b0, zeros_len} > (ZW+1)'(MAX_ZEROS))
      k_in = ZW'(MAX_ZEROS);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      k_q        <= '0;
      gap_q      <= '0;
      rem_q      <= '0;
      sig_out    <= 1'b0;
      sig_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_tick <= 1'b0;
      count_bcd  <= 8'h00;
      disp0      <= 8'hC0;
      disp1      <= 8'hC0;
    end else if (ena) begin
      state      <= state_d;
      k_q        <= k_d;
      gap_q      <= gap_d;
      rem_q      <= rem_d;
      sig_out    <= so_d;
      sig_valid  <= sv_d;
      busy       <= busy_d;
      done       <= done_d;
      frame_tick <= tick_d;
      count_bcd  <= bcd_d;
      disp0      <= disp0_d;
      disp1      <= disp1_d;
    end
  end

  always_comb begin
    state_d = state;
    k_d     = k_q;
    gap_d   = gap_q;
    rem_d   = rem_q;
    bcd_d   = count_bcd;
    unique case (state)
      IDLE: begin
        if (start) begin
          k_d   = k_in;
          rem_d = num_frames;
          if (num_frames != '0)
            state_d = LEAD0;
        end
      end
      LEAD0: state_d = LEAD1;
      LEAD1: begin
        if (k_q != '0) begin
          state_d = GAP;
          gap_d   = k_q;
        end else begin
          state_d = END1;
        end
      end
      GAP: begin
        if (gap_q == ZW'(1))
          state_d = END1;
        else
          gap_d = gap_q - 1'b1;
      end
      END1: begin
        bcd_d = bcd_inc(count_bcd);
        if (rem_q == FRAME_W'(1)) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_q - 1'b1;
`ifdef SEQGEN_IDLE_GAP_EN
          state_d = SPACE;
`else
          state_d = LEAD0;
`endif
        end
      end
      SPACE:   state_d = LEAD0;
      default: state_d = IDLE;
    endcase
  end

  // next-cycle output values, registered alongside the state
  always_comb begin
    so_d    = (state_d == LEAD1) || (state_d == END1);
    sv_d    = (state_d == LEAD0) || (state_d == LEAD1) ||
              (state_d == GAP)   || (state_d == END1);
    busy_d  = (state_d != IDLE);
    tick_d  = (state_d == END1);
    done_d  = ((state == END1) && (state_d == IDLE)) ||
              ((state == IDLE) && start && (num_frames == '0));
    disp0_d = seg7(bcd_d[3:0]);
    disp1_d = seg7(bcd_d[7:4]);
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: vector table plus burst,
// wrap and abort sequences.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       rst, ena, start;
  logic [3:0] zeros_len;
  logic [7:0] num_frames;
  logic       sig_out, sig_valid, busy, done, frame_tick;
  logic [7:0] count_bcd, disp0, disp1;

  int checks = 0;
  int errors = 0;

  sequence_generator dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .start      (start),
    .zeros_len  (zeros_len),
    .num_frames (num_frames),
    .sig_out    (sig_out),
    .sig_valid  (sig_valid),
    .busy       (busy),
    .done       (done),
    .frame_tick (frame_tick),
    .count_bcd  (count_bcd),
    .disp0      (disp0),
    .disp1      (disp1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ena, start;
    logic [3:0] k;
    logic [7:0] n;
    logic       so, sv, bz, dn, ft;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  logic [28:0] act;
  assign act = {sig_out, sig_valid, busy, done, frame_tick,
                count_bcd, disp0, disp1};

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0: s = 8'hC0;
      4'd1: s = 8'hF9;
      4'd2: s = 8'hA4;
      4'd3: s = 8'hB0;
      4'd4: s = 8'h99;
      4'd5: s = 8'h92;
      4'd6: s = 8'h82;
      4'd7: s = 8'hF8;
      4'd8: s = 8'h80;
      4'd9: s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [28:0] mk(input logic so, sv, bz, dn, ft,
                                     input logic [7:0] c);
    return {so, sv, bz, dn, ft, c, seg(c[3:0]), seg(c[7:4])};
  endfunction

  function automatic void add(input logic e, s, input int k, n,
                              input logic so, sv, bz, dn, ft,
                              input logic [7:0] c);
    vec_t v;
    v.rst = 1'b1; v.ena = e; v.start = s;
    v.k = 4'(k); v.n = 8'(n);
    v.so = so; v.sv = sv; v.bz = bz; v.dn = dn; v.ft = ft;
    v.cnt = c;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic r, e, s, input int k, n);
    rst = r; ena = e; start = s;
    zeros_len = 4'(k); num_frames = 8'(n);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] a, e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  task automatic run_burst(input int k, n, input string nm);
    int bits, ticks, cyc;
    bits = 0; ticks = 0; cyc = 0;
    step(1, 1, 1, k, n);
    while (!done && cyc < 3000) begin
      bits  += int'(sig_valid);
      ticks += int'(frame_tick);
      step(1, 1, 0, 0, 0);
      cyc++;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_bits"}, 32'(bits), 32'(n * (k + 3)));
    chk({nm, "_ticks"}, 32'(ticks), 32'(n));
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; start = 1'b0;
    zeros_len = '0; num_frames = '0;

    // single frame k=2
    add(1,1,2,1, 0,1,1,0,0, 8'h00);
    add(1,0,0,0, 1,1,1,0,0, 8'h00);
    add(1,0,0,0, 0,1,1,0,0, 8'h00);
    add(1,0,0,0, 0,1,1,0,0, 8'h00);
    add(1,0,0,0, 1,1,1,0,1, 8'h00);
    add(1,0,0,0, 0,0,0,1,0, 8'h01);
    add(1,0,0,0, 0,0,0,0,0, 8'h01);
    // k=0, three frames back to back
    add(1,1,0,3, 0,1,1,0,0, 8'h01);
    add(1,0,0,0, 1,1,1,0,0, 8'h01);
    add(1,0,0,0, 1,1,1,0,1, 8'h01);
    add(1,0,0,0, 0,1,1,0,0, 8'h02);
    add(1,0,0,0, 1,1,1,0,0, 8'h02);
    add(1,0,0,0, 1,1,1,0,1, 8'h02);
    add(1,0,0,0, 0,1,1,0,0, 8'h03);
    add(1,0,0,0, 1,1,1,0,0, 8'h03);
    add(1,0,0,0, 1,1,1,0,1, 8'h03);
    add(1,0,0,0, 0,0,0,1,0, 8'h04);
    // ena stall after the second bit
    add(1,1,1,1, 0,1,1,0,0, 8'h04);
    add(1,0,0,0, 1,1,1,0,0, 8'h04);
    add(0,0,0,0, 1,1,1,0,0, 8'h04);
    add(0,0,0,0, 1,1,1,0,0, 8'h04);
    add(0,0,0,0, 1,1,1,0,0, 8'h04);
    add(1,0,0,0, 0,1,1,0,0, 8'h04);
    add(1,0,0,0, 1,1,1,0,1, 8'h04);
    add(1,0,0,0, 0,0,0,1,0, 8'h05);
    // empty burst, done held through a stall
    add(1,1,0,0, 0,0,0,1,0, 8'h05);
    add(0,0,0,0, 0,0,0,1,0, 8'h05);
    add(1,0,0,0, 0,0,0,0,0, 8'h05);
    // start while busy ignored, held start restarts after done
    add(1,1,0,1, 0,1,1,0,0, 8'h05);
    add(1,1,5,9, 1,1,1,0,0, 8'h05);
    add(1,1,5,9, 1,1,1,0,1, 8'h05);
    add(1,1,0,1, 0,0,0,1,0, 8'h06);
    add(1,1,0,1, 0,1,1,0,0, 8'h06);
    add(1,0,0,0, 1,1,1,0,0, 8'h06);
    add(1,0,0,0, 1,1,1,0,1, 8'h06);
    add(1,0,0,0, 0,0,0,1,0, 8'h07);
    add(1,0,0,0, 0,0,0,0,0, 8'h07);

    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("reset", 32'(act), 32'(mk(0,0,0,0,0, 8'h00)));
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 0);
      chk($sformatf("idle%0d", i), 32'(act), 32'(mk(0,0,0,0,0, 8'h00)));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].ena, tbl[i].start, int'(tbl[i].k), int'(tbl[i].n));
      chk($sformatf("vec%0d", i), 32'(act),
          32'(mk(tbl[i].so, tbl[i].sv, tbl[i].bz, tbl[i].dn, tbl[i].ft, tbl[i].cnt)));
    end

    run_burst(0, 92, "to99");
    chk("at99", 32'(act), 32'(mk(0,0,0,1,0, 8'h99)));
    run_burst(0, 1, "wrap");
    chk("wrap00", 32'(act), 32'(mk(0,0,0,1,0, 8'h00)));
    run_burst(15, 2, "kmax");
    chk("kmax_cnt", 32'(act), 32'(mk(0,0,0,1,0, 8'h02)));

    step(1, 1, 1, 3, 5);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
    chk("abort_gap", 32'(act), 32'(mk(0,1,1,0,0, 8'h03)));
    step(0, 1, 0, 0, 0);
    chk("abort_rst", 32'(act), 32'(mk(0,0,0,0,0, 8'h00)));
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0);
      chk($sformatf("abort_idle%0d", i), 32'(act), 32'(mk(0,0,0,0,0, 8'h00)));
    end

    step(1, 1, 1, 4, 0);
    chk("n0_done", 32'(act), 32'(mk(0,0,0,1,0, 8'h00)));
    step(1, 1, 0, 0, 0);
    chk("n0_after", 32'(act), 32'(mk(0,0,0,0,0, 8'h00)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
